// File: rtl/mem_pkg.sv
// Shared encodings for the memory access stage.
// Writeback selects, access sizes, fault codes and FSM states.
package mem_pkg;

    localparam logic [1:0] WB_PC  = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_MEM = 2'd2;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_OVERSIZE = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane positioning for stores, byte enables, and load
// extraction with sign/zero extension. Purely combinational.
module mem_lane_align #(
    parameter int DATA_W = 16,
    localparam int BYTES = DATA_W / 8,
    localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1
) (
    input  logic [LANE_W-1:0] lane_i,
    input  logic [1:0]        size_i,
    input  logic              sign_ext_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [DATA_W-1:0] wdata_o,
    output logic [BYTES-1:0]  be_o,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] wmask;
    logic [BYTES-1:0]  bmask;
    logic [3:0]        nb;
    logic              sign_b;

    always_comb begin
        nb      = 4'd1 << size_i;
        shifted = rdata_i >> {lane_i, 3'b000};
        wmask   = '0;
        bmask   = '0;
        rdata_o = '0;
        sign_b  = 1'b0;
        for (int b = 0; b < BYTES; b++) begin
            if (b < int'(nb)) begin
                wmask[8*b +: 8]   = wdata_i[8*b +: 8];
                bmask[b]          = 1'b1;
                rdata_o[8*b +: 8] = shifted[8*b +: 8];
                sign_b            = sign_ext_i & shifted[8*b+7];
            end
        end
        // Bytes above the access width take the extension bit.
        for (int b = 0; b < BYTES; b++) begin
            if (b >= int'(nb)) begin
                rdata_o[8*b +: 8] = {8{sign_b}};
            end
        end
        wdata_o = wmask << {lane_i, 3'b000};
        be_o    = bmask << lane_i;
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: issues data-memory requests, waits for ack or
// timeout, aligns load data and selects the writeback value.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic [DATA_W-1:0]   immediate,
    input  logic [DATA_W-1:0]   pc,
    input  logic [DATA_W-1:0]   store_data,
    input  logic                data_in_src,
    input  logic                mem_rd,
    input  logic                mem_wr,
    input  logic [1:0]          size,
    input  logic                sign_ext,
    input  logic [1:0]          wb_sel,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                wb_valid,
    output logic [DATA_W-1:0]   wb_data,
    output logic                err,
    output logic [1:0]          err_code
);

    localparam int BYTES  = DATA_W / 8;
    localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_e              state_q, state_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BYTES-1:0]    be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                wbv_q, wbv_d;
    logic [DATA_W-1:0]   wbd_q, wbd_d;
    logic                err_q, err_d;
    logic [1:0]          code_q, code_d;
    logic [DATA_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   alu_q, alu_d;
    logic [1:0]          sel_q, sel_d;
    logic [1:0]          size_q, size_d;
    logic                sext_q, sext_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic                store_q, store_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [ADDR_W-1:0]   addr;
    logic [LANE_W-1:0]   lane;
    logic                is_mem;
    logic                oversize;
    logic                misalign;
    logic [LANE_W-1:0]   al_lane;
    logic [1:0]          al_size;
    logic [DATA_W-1:0]   al_wdata;
    logic [BYTES-1:0]    al_be;
    logic [DATA_W-1:0]   al_rdata;

    assign addr     = alu_result[ADDR_W-1:0];
    assign lane     = addr[LANE_W-1:0];
    assign is_mem   = mem_rd | mem_wr;
    assign oversize = int'(size) > LANE_W;
    assign misalign = (int'(lane) & ((1 << size) - 1)) != 0;

    // The aligner serves the new op in IDLE and the latched op in ACCESS.
    assign al_lane = (state_q == ST_IDLE) ? lane : lane_q;
    assign al_size = (state_q == ST_IDLE) ? size : size_q;

    mem_lane_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .lane_i     (al_lane),
        .size_i     (al_size),
        .sign_ext_i (sext_q),
        .wdata_i    (data_in_src ? store_data : immediate),
        .rdata_i    (mem_rdata),
        .wdata_o    (al_wdata),
        .be_o       (al_be),
        .rdata_o    (al_rdata)
    );

    function automatic logic [DATA_W-1:0] wb_mux(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] p,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] l
    );
        case (sel)
            WB_PC:   wb_mux = p;
            WB_ALU:  wb_mux = a;
            default: wb_mux = l;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        wbv_d   = 1'b0;
        wbd_d   = wbd_q;
        err_d   = 1'b0;
        code_d  = ERR_NONE;
        pc_d    = pc_q;
        alu_d   = alu_q;
        sel_d   = sel_q;
        size_d  = size_q;
        sext_d  = sext_q;
        lane_d  = lane_q;
        store_d = store_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && !is_mem) begin
                    wbv_d = 1'b1;
                    wbd_d = wb_mux(wb_sel, pc, alu_result, '0);
                end else if (in_valid && (oversize || misalign)) begin
                    wbv_d  = 1'b1;
                    err_d  = 1'b1;
                    code_d = oversize ? ERR_OVERSIZE : ERR_MISALIGN;
                    wbd_d  = '0;
                end else if (in_valid) begin
                    req_d   = 1'b1;
                    we_d    = mem_wr;
                    addr_d  = {addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
                    be_d    = al_be;
                    wdata_d = al_wdata;
                    pc_d    = pc;
                    alu_d   = alu_result;
                    sel_d   = wb_sel;
                    size_d  = size;
                    sext_d  = sign_ext;
                    lane_d  = lane;
                    store_d = mem_wr;
                    cnt_d   = '0;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (mem_ack) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    wbv_d   = 1'b1;
                    wbd_d   = wb_mux(sel_q, pc_q, alu_q,
                                     store_q ? alu_q : al_rdata);
                    state_d = ST_IDLE;
                end else if (TIMEOUT > 0 &&
                             cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    wbv_d   = 1'b1;
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                    wbd_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            wbv_q   <= 1'b0;
            wbd_q   <= '0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            pc_q    <= '0;
            alu_q   <= '0;
            sel_q   <= '0;
            size_q  <= '0;
            sext_q  <= 1'b0;
            lane_q  <= '0;
            store_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            wbv_q   <= wbv_d;
            wbd_q   <= wbd_d;
            err_q   <= err_d;
            code_q  <= code_d;
            pc_q    <= pc_d;
            alu_q   <= alu_d;
            sel_q   <= sel_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            lane_q  <= lane_d;
            store_q <= store_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign wb_valid  = wbv_q;
    assign wb_data   = wbd_q;
    assign err       = err_q;
    assign err_code  = code_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed plus randomized bench for mem_access_stage (16- and
// 32-bit instances) against an arithmetic reference model.
module tb_mem_access_stage;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        in_valid, in_ready;
    logic [15:0] alu_result, immediate, pc, store_data;
    logic        data_in_src, mem_rd, mem_wr, sign_ext;
    logic [1:0]  size, wb_sel;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, wb_data;
    logic [1:0]  mem_be, err_code;
    logic        wb_valid, err;

    logic        in_valid32, in_ready32;
    logic [31:0] alu32, imm32, pc32, sd32;
    logic        src32, rd32, wr32, sx32;
    logic [1:0]  size32, sel32;
    logic        req32, we32, ack32;
    logic [15:0] addr32;
    logic [3:0]  be32;
    logic [31:0] wdata32, rdata32, wbd32;
    logic        wbv32, err32;
    logic [1:0]  code32;

    int checks = 0;
    int errors = 0;

    mem_access_stage #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .immediate(immediate),
        .pc(pc), .store_data(store_data),
        .data_in_src(data_in_src), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .size(size), .sign_ext(sign_ext), .wb_sel(wb_sel),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_data(wb_data),
        .err(err), .err_code(err_code)
    );

    mem_access_stage #(.DATA_W(32), .ADDR_W(16), .TIMEOUT(TMO)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid32), .in_ready(in_ready32),
        .alu_result(alu32), .immediate(imm32),
        .pc(pc32), .store_data(sd32),
        .data_in_src(src32), .mem_rd(rd32), .mem_wr(wr32),
        .size(size32), .sign_ext(sx32), .wb_sel(sel32),
        .mem_req(req32), .mem_we(we32), .mem_addr(addr32),
        .mem_be(be32), .mem_wdata(wdata32),
        .mem_ack(ack32), .mem_rdata(rdata32),
        .wb_valid(wbv32), .wb_data(wbd32),
        .err(err32), .err_code(code32)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One instruction on the 16-bit instance; dly = cycles before ack,
    // dly >= TMO means the ack is withheld.
    task automatic do_op(input logic rd, input logic wr,
                         input logic [1:0] sz, input logic [1:0] sel,
                         input logic sx, input logic src,
                         input logic [15:0] alu, input logic [15:0] imm,
                         input logic [15:0] pcv, input logic [15:0] sd,
                         input logic [15:0] rdat, input int dly);
        longint nb, ln, code, sdat, v, full;
        logic [15:0] eres, ewd, eaddr;
        logic [1:0]  ebe;
        nb   = longint'(1) << sz;
        ln   = alu % 2;
        code = 0;
        if (rd || wr) begin
            if (nb > 2) code = 2;
            else if (ln % nb != 0) code = 1;
        end
        full  = longint'(1) << (8 * nb);
        sdat  = src ? sd : imm;
        ewd   = 16'((sdat % full) << (8 * ln));
        ebe   = 2'(((longint'(1) << nb) - 1) << ln);
        eaddr = 16'(alu - ln);
        v = (longint'(rdat) >> (8 * ln)) % full;
        if (sx && v >= full / 2) v = v - full;
        if (sel == 0) eres = pcv;
        else if (sel == 1) eres = alu;
        else if (rd && !wr) eres = 16'(v);
        else if (wr) eres = alu;
        else eres = 16'h0;

        chk("in_ready_idle", in_ready, 1);
        in_valid = 1; mem_rd = rd; mem_wr = wr; size = sz;
        wb_sel = sel; sign_ext = sx; data_in_src = src;
        alu_result = alu; immediate = imm; pc = pcv; store_data = sd;
        step();
        in_valid = 0;
        if (!(rd || wr) || code != 0) begin
            chk("imm_wb_valid", wb_valid, 1);
            chk("imm_err", err, code != 0);
            chk("imm_err_code", err_code, 32'(code));
            chk("imm_wb_data", wb_data, code != 0 ? 16'h0 : eres);
            chk("imm_no_req", mem_req, 0);
        end else begin
            chk("req", mem_req, 1);
            chk("we", mem_we, wr);
            chk("addr", mem_addr, eaddr);
            chk("be", mem_be, ebe);
            if (wr) chk("wdata", mem_wdata, ewd);
            chk("busy", in_ready, 0);
            if (dly < TMO) begin
                repeat (dly) begin
                    step();
                    chk("req_held", mem_req, 1);
                    chk("busy_held", in_ready, 0);
                end
                mem_ack = 1; mem_rdata = rdat;
                step();
                mem_ack = 0; mem_rdata = $urandom;
                chk("done_valid", wb_valid, 1);
                chk("done_data", wb_data, eres);
                chk("done_err", err, 0);
                chk("done_req", mem_req, 0);
            end else begin
                repeat (TMO - 1) step();
                chk("tmo_req_held", mem_req, 1);
                step();
                chk("tmo_valid", wb_valid, 1);
                chk("tmo_err", err, 1);
                chk("tmo_code", err_code, 3);
                chk("tmo_data", wb_data, 0);
                chk("tmo_req_drop", mem_req, 0);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; in_valid = 0; mem_ack = 0; mem_rdata = 0;
        alu_result = 0; immediate = 0; pc = 0; store_data = 0;
        data_in_src = 0; mem_rd = 0; mem_wr = 0; size = 0;
        sign_ext = 0; wb_sel = 0;
        in_valid32 = 0; ack32 = 0; rdata32 = 0; alu32 = 0; imm32 = 0;
        pc32 = 0; sd32 = 0; src32 = 0; rd32 = 0; wr32 = 0;
        size32 = 0; sx32 = 0; sel32 = 0;
        #12;
        chk("rst_ready", in_ready, 1);
        chk("rst_req", mem_req, 0);
        chk("rst_wbv", wb_valid, 0);
        chk("rst_err", {err, err_code}, 0);
        chk("rst_bus", {mem_we, mem_be, mem_addr, mem_wdata}, 0);
        rst_n = 1;
        step();

        do_op(0, 0, 0, 1, 0, 0, 16'h1234, 0, 16'h0100, 0, 0, 0);
        do_op(1, 0, 0, 2, 1, 0, 16'h0003, 0, 0, 0, 16'h80FF, 3);
        do_op(0, 1, 0, 2, 0, 0, 16'h0005, 16'h00AB, 0, 16'h5555, 0, 1);
        do_op(0, 1, 1, 1, 0, 0, 16'h0005, 16'h00AB, 0, 0, 0, 0);
        do_op(1, 0, 2, 2, 0, 0, 16'h0004, 0, 0, 0, 0, 0);
        do_op(0, 0, 0, 3, 0, 0, 16'h7777, 0, 16'h2222, 0, 0, 0);
        do_op(1, 1, 1, 2, 0, 1, 16'h0010, 0, 0, 16'hCAFE, 0, 2);
        do_op(1, 0, 1, 2, 1, 0, 16'h0020, 0, 0, 0, 16'h8001, 0);
        do_op(1, 0, 0, 0, 0, 0, 16'h0040, 0, 16'h0ABC, 0, 0, TMO);
        do_op(0, 0, 0, 1, 0, 0, 16'h4321, 0, 0, 0, 0, 0);

        for (int i = 0; i < 200; i++) begin
            logic [1:0] kind;
            int dly;
            kind = 2'($urandom_range(0, 3));
            dly = ($urandom_range(0, 19) == 0) ? TMO + 2
                                              : $urandom_range(0, 5);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
            do_op(kind[0], kind[1],
                  2'(($urandom_range(0, 5) == 0) ? $urandom_range(2, 3)
                                                 : $urandom_range(0, 1)),
                  2'($urandom), 1'($urandom), 1'($urandom),
                  16'($urandom), 16'($urandom), 16'($urandom),
                  16'($urandom), 16'($urandom), dly);
        end

        in_valid32 = 1; rd32 = 1; size32 = 3; alu32 = 0; sel32 = 2;
        step();
        in_valid32 = 0;
        chk("w32_over_valid", wbv32, 1);
        chk("w32_over_code", code32, 2);
        chk("w32_over_req", req32, 0);
        in_valid32 = 1; rd32 = 1; size32 = 1; sx32 = 0;
        alu32 = 32'h0000_0002; sel32 = 2;
        step();
        in_valid32 = 0;
        chk("w32_req", req32, 1);
        chk("w32_addr", addr32, 0);
        chk("w32_be", be32, 4'b1100);
        ack32 = 1; rdata32 = 32'hBEEF_0000;
        step();
        ack32 = 0;
        chk("w32_valid", wbv32, 1);
        chk("w32_data", wbd32, 32'h0000_BEEF);

        in_valid = 1; mem_rd = 1; mem_wr = 0; size = 0;
        alu_result = 16'h0003; wb_sel = 2;
        step();
        in_valid = 0;
        chk("rst_mid_req", mem_req, 1);
        step();
        rst_n = 0;
        #1;
        chk("rst_mid_req0", mem_req, 0);
        chk("rst_mid_ready", in_ready, 1);
        chk("rst_mid_bus", {mem_we, mem_be, mem_addr, mem_wdata}, 0);
        chk("rst_mid_wb", {wb_valid, wb_data, err, err_code}, 0);
        #2;
        rst_n = 1;
        mem_ack = 1; mem_rdata = 16'h1234;
        step();
        chk("stray_ack_wbv", wb_valid, 0);
        step();
        mem_ack = 0;
        chk("stray_ack_wbv2", wb_valid, 0);
        chk("stray_ack_req", mem_req, 0);
        do_op(0, 0, 0, 1, 0, 0, 16'h9999, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Parametrised memory stage of the 5-stage pipeline. It sits between the EX/MEM and MEM/WB pipeline registers.
- Takes an ALU result, immediate, PC and register store-data. Selects store data, drives a variable-latency data-memory port with byte enables, aligns and extends load data, and selects the writeback value.
- Stalls upstream through a valid/ready handshake while a memory access is outstanding. Flags misaligned, oversize and timed-out accesses.

Parameters:
- DATA_W, 16, datapath and memory word width; multiple of 8, minimum 16.
- ADDR_W, 16, byte address width.
- TIMEOUT, 15, maximum cycles waiting for mem_ack before aborting; 0 disables the timeout.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  EX/MEM holds a valid instruction.
- in_ready  out  1  stage accepts this cycle.
- alu_result  in  DATA_W  effective address (low ADDR_W bits) or ALU value.
- immediate  in  DATA_W  immediate store operand.
- pc  in  DATA_W  return-address value.
- store_data  in  DATA_W  register store operand.
- data_in_src  in  1  1 selects store_data, 0 selects immediate.
- mem_rd  in  1  load.
- mem_wr  in  1  store.
- size  in  2  access bytes = 2^size.
- sign_ext  in  1  load extension, 1 signed, 0 zero.
- wb_sel  in  2  0 = pc, 1 = alu_result, 2/3 = load data.
- mem_req  out  1  memory request.
- mem_we  out  1  write request.
- mem_addr  out  ADDR_W  word-aligned address.
- mem_be  out  DATA_W/8  byte enables.
- mem_wdata  out  DATA_W  lane-positioned store data.
- mem_ack  in  1  memory completes the request; mem_rdata valid the same cycle.
- mem_rdata  in  DATA_W  read word.
- wb_valid  out  1  wb_data valid, one-cycle pulse per instruction.
- wb_data  out  DATA_W  writeback value.
- err  out  1  pulse alongside wb_valid on an access fault.
- err_code  out  2  1 = misaligned, 2 = oversize, 3 = timeout; 0 otherwise.

Behaviour:
- Reset (asynchronous, rst_n low):
  - State becomes IDLE.
  - mem_req, mem_we, mem_be, mem_addr, mem_wdata, wb_valid, wb_data, err, err_code all go to 0.
  - in_ready goes to 1.
  - An outstanding request is dropped; a late mem_ack arriving in IDLE is ignored.
- Derived quantities, all in IDLE:
  - BYTES = DATA_W/8.
  - lane = address mod BYTES.
  - nbytes = 2^size.
- Fault detection on acceptance:
  - Oversize when nbytes > BYTES.
  - Misaligned when lane mod nbytes ≠ 0.
  - Oversize has priority over misaligned.
  - mem_rd and mem_wr both high is treated as a store.
- FSM states: IDLE, ACCESS.
- IDLE:
  - in_ready = 1.
  - in_valid with no mem_rd/mem_wr: next cycle wb_valid = 1, wb_data = mux(wb_sel). Latency 1. wb_sel 2/3 without a load yields 0.
  - in_valid with a fault: no request issued. Next cycle wb_valid = 1, err = 1, err_code set, wb_data = 0.
  - in_valid with a legal memory op: latch the operands. Register mem_req = 1 next cycle. Set mem_addr = address with low log2(BYTES) bits cleared. Set mem_be = ((1<<nbytes) - 1) << lane. Set mem_wdata = selected store data (low nbytes bytes) shifted left by lane*8. mem_we = mem_wr. Go to ACCESS.
- ACCESS:
  - in_ready = 0.
  - mem_req and all request fields are held stable until mem_ack.
  - On mem_ack: mem_req drops next cycle. Load data = (mem_rdata >> lane*8), masked to nbytes and sign- or zero-extended to DATA_W. Next cycle wb_valid = 1, wb_data = mux(wb_sel) using latched pc/alu and the load data. A store reports the latched alu_result when wb_sel selects load data. Return to IDLE; in_ready is 1 in that cycle.
  - Wait counter: when TIMEOUT > 0 and the counter reaches TIMEOUT with no ack, drop mem_req, emit wb_valid with err = 1, err_code = 3, wb_data = 0, and return to IDLE.
- Back-to-back operation: a new instruction is accepted in the same cycle that the previous wb_valid pulses (IDLE-cycle acceptance). Throughput is one per cycle for non-memory ops and one per (latency+1) cycles for memory ops.
- Outputs are registered; no combinational path from mem_ack to in_ready or wb_data.

Decomposition:
- Shared package mem_pkg holds:
  - WB_PC / WB_ALU / WB_MEM encodings.
  - SIZE_B/H/W/D encodings.
  - ERR_* codes.
  - The state enum.
- One sub-module, mem_lane_align: purely combinational store-lane positioning, byte-enable generation, and load extract/extend. Parametrised by DATA_W; reused by the instruction-fetch path later.

Test Plan (DATA_W = 16 unless stated):
- Non-memory op, wb_sel = 1, alu_result = 0x1234 -> wb_valid one cycle later, wb_data = 0x1234, mem_req never asserted.
- Signed byte load from address 0x0003, mem_ack after 3 cycles with rdata = 0x80FF -> mem_addr = 0x0002, mem_be = 2'b10, in_ready low for 4 cycles, wb_data = 0xFF80.
- Byte store of immediate 0x00AB to 0x0005 with data_in_src = 0 -> mem_we = 1, mem_be = 2'b10, mem_wdata = 0xAB00. Halfword store to 0x0005 -> err_code = 1, no mem_req.
- DATA_W = 32: size = 3 -> err_code = 2. Zero-extended halfword load from 0x...2 with rdata = 0xBEEF0000 -> wb_data = 0x0000BEEF.
- mem_ack withheld, TIMEOUT = 15 -> mem_req drops after 15 cycles, err_code = 3, next instruction accepted.
- rst_n pulsed low mid-ACCESS -> all outputs 0 immediately, in_ready = 1. A subsequent stray mem_ack produces no wb_valid.
